fft_output_reader: RTL and testbench

Unloads a completed FFT frame from the dual-read-port complex RAM and emits it as a one-sample-per-cycle valid/ready stream in natural frequency order. Output addresses are bit-reversed by default. The block reads two RAM words per fetch and holds them in a two-entry output buffer. It sits between the butterfly RAM's read side and the downstream consumer, such as a magnitude stage or an output FIFO.

---
 rtl/fft_output_reader.sv | 150 +++++++++++++++
 tb/tb_fft_output_reader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_output_reader.sv
// Streams a finished FFT frame out of a dual-read-port RAM in natural frequency
// order, fetching two samples per read and presenting them on a valid/ready port.
module fft_output_reader #(
  parameter int vector_size = 16,
  parameter int N           = 16,
  parameter bit BIT_REVERSE = 1'b1,
  localparam int AW         = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [AW-1:0]          read_address1,
  output logic [AW-1:0]          read_address2,
  input  logic [vector_size-1:0] in_real1,
  input  logic [vector_size-1:0] in_im1,
  input  logic [vector_size-1:0] in_real2,
  input  logic [vector_size-1:0] in_im2,
  output logic [vector_size-1:0] out_real,
  output logic [vector_size-1:0] out_im,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [AW-1:0]          out_index
);

  localparam bit HAS_P = (AW > 1);
  localparam int PW    = HAS_P ? AW - 1 : 1;
  localparam int DW    = 2 * vector_size;
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND0, S_SEND1, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   p_q, p_d;
  logic [AW-1:0]   c_q, c_d;
  logic [DW-1:0]   buf0_q, buf0_d;
  logic [DW-1:0]   buf1_q, buf1_d;
  logic [PW-1:0]   p_inc;
  logic [AW-1:0]   pair_base;

  function automatic logic [AW-1:0] map_addr(input logic [AW-1:0] i);
    logic [AW-1:0] r;
    r = i;
    if (BIT_REVERSE) begin
      for (int b = 0; b < AW; b++) r[b] = i[AW-1-b];
    end
    return r;
  endfunction

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the values present before the edge, regardless of process order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the sample buffers are cleared too, so stale frame data never
      // reaches out_real/out_im after a reset.
      state_q <= S_IDLE;
      p_q     <= '0;
      c_q     <= '0;
      buf0_q  <= '0;
      buf1_q  <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      c_q     <= c_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
    end
  end

  // The pointer saturates on the final pair rather than wrapping; N=2 has no pointer.
  always_comb begin
    p_inc = p_q;
    if (HAS_P && (p_q != {PW{1'b1}})) p_inc = p_q + PW'(1);
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    state_d = state_q;
    p_d     = p_q;
    c_d     = c_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          p_d     = '0;
          c_d     = '0;
        end
      end
      S_FETCH: begin
        buf0_d  = {in_real1, in_im1};
        buf1_d  = {in_real2, in_im2};
        p_d     = p_inc;
        state_d = S_SEND0;
      end
      S_SEND0: begin
        if (out_ready) begin
          c_d     = c_q + AW'(1);
          state_d = S_SEND1;
        end
      end
      S_SEND1: begin
        if (out_ready) begin
          if (c_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            // Reload the next pair on the same edge so the stream has no bubble.
            buf0_d  = {in_real1, in_im1};
            buf1_d  = {in_real2, in_im2};
            p_d     = p_inc;
            c_d     = c_q + AW'(1);
            state_d = S_SEND0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pair_base     = AW'({p_q, 1'b0});
    busy          = (state_q == S_FETCH) || (state_q == S_SEND0) || (state_q == S_SEND1);
    done          = (state_q == S_DONE);
    out_valid     = (state_q == S_SEND0) || (state_q == S_SEND1);
    out_index     = c_q;
    out_last      = out_valid && (c_q == LAST_IDX);
    out_real      = '0;
    out_im        = '0;
    read_address1 = '0;
    read_address2 = '0;
    if (state_q == S_SEND0) begin
      out_real = buf0_q[DW-1:vector_size];
      out_im   = buf0_q[vector_size-1:0];
    end else if (state_q == S_SEND1) begin
      out_real = buf1_q[DW-1:vector_size];
      out_im   = buf1_q[vector_size-1:0];
    end
    // Addresses are parked at zero outside a frame so the outputs are all-zero when idle.
    if (busy) begin
      read_address1 = map_addr(pair_base);
      read_address2 = map_addr(pair_base | AW'(1));
    end
  end

endmodule

// File: tb/tb_fft_output_reader.sv
// Self-checking bench: three reader instances (N=8 bit-reversed, N=8 natural,
// N=2) share one behavioural RAM and are compared against an index-order model.
module tb_fft_output_reader;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic ready;
  int   sel;
  logic [31:0] mem [8];

  int checks = 0;
  int errors = 0;

  // Instance A: N=8, bit-reversed
  logic        busy_a, done_a, valid_a, last_a;
  logic [2:0]  a1_a, a2_a, idx_a;
  logic [W-1:0] re_a, im_a;
  // Instance B: N=8, natural order
  logic        busy_b, done_b, valid_b, last_b;
  logic [2:0]  a1_b, a2_b, idx_b;
  logic [W-1:0] re_b, im_b;
  // Instance C: N=2, bit-reversed
  logic        busy_c, done_c, valid_c, last_c;
  logic [0:0]  a1_c, a2_c, idx_c;
  logic [W-1:0] re_c, im_c;

  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b, rd1_c, rd2_c;
  assign rd1_a = mem[a1_a];
  assign rd2_a = mem[a2_a];
  assign rd1_b = mem[a1_b];
  assign rd2_b = mem[a2_b];
  assign rd1_c = mem[{2'b00, a1_c}];
  assign rd2_c = mem[{2'b00, a2_c}];

  fft_output_reader #(.vector_size(W), .N(8), .BIT_REVERSE(1'b1)) dut_a (
    .clk(clk), .reset(rst), .start(start && sel == 0), .busy(busy_a), .done(done_a),
    .read_address1(a1_a), .read_address2(a2_a),
    .in_real1(rd1_a[31:16]), .in_im1(rd1_a[15:0]), .in_real2(rd2_a[31:16]), .in_im2(rd2_a[15:0]),
    .out_real(re_a), .out_im(im_a), .out_valid(valid_a), .out_ready(ready),
    .out_last(last_a), .out_index(idx_a));

  fft_output_reader #(.vector_size(W), .N(8), .BIT_REVERSE(1'b0)) dut_b (
    .clk(clk), .reset(rst), .start(start && sel == 1), .busy(busy_b), .done(done_b),
    .read_address1(a1_b), .read_address2(a2_b),
    .in_real1(rd1_b[31:16]), .in_im1(rd1_b[15:0]), .in_real2(rd2_b[31:16]), .in_im2(rd2_b[15:0]),
    .out_real(re_b), .out_im(im_b), .out_valid(valid_b), .out_ready(ready),
    .out_last(last_b), .out_index(idx_b));

  fft_output_reader #(.vector_size(W), .N(2), .BIT_REVERSE(1'b1)) dut_c (
    .clk(clk), .reset(rst), .start(start && sel == 2), .busy(busy_c), .done(done_c),
    .read_address1(a1_c), .read_address2(a2_c),
    .in_real1(rd1_c[31:16]), .in_im1(rd1_c[15:0]), .in_real2(rd2_c[31:16]), .in_im2(rd2_c[15:0]),
    .out_real(re_c), .out_im(im_c), .out_valid(valid_c), .out_ready(ready),
    .out_last(last_c), .out_index(idx_c));

  always #5 clk = ~clk;

  // Observation mux onto the instance under test
  logic        o_busy, o_done, o_valid, o_last;
  logic [2:0]  o_a1, o_a2, o_idx;
  logic [31:0] o_data;
  always_comb begin
    o_busy = busy_a; o_done = done_a; o_valid = valid_a; o_last = last_a;
    o_a1 = a1_a; o_a2 = a2_a; o_idx = idx_a; o_data = {re_a, im_a};
    if (sel == 1) begin
      o_busy = busy_b; o_done = done_b; o_valid = valid_b; o_last = last_b;
      o_a1 = a1_b; o_a2 = a2_b; o_idx = idx_b; o_data = {re_b, im_b};
    end else if (sel == 2) begin
      o_busy = busy_c; o_done = done_c; o_valid = valid_c; o_last = last_c;
      o_a1 = {2'b00, a1_c}; o_a2 = {2'b00, a2_c}; o_idx = {2'b00, idx_c}; o_data = {re_c, im_c};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RAM location holding natural-order sample k: reversed binary digits of k.
  function automatic int ref_map(input int k, input int n, input bit br);
    int r, x, bits;
    if (!br) return k;
    bits = $clog2(n);
    r = 0;
    x = k;
    for (int b = 0; b < bits; b++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  task automatic run_frame(input int sel_i, input int ready_mode, input bit spam,
                           input int abort_at, input bit ramp);
    int n, k, cyc, rcnt;
    bit br, stalled, aborted, rv;
    logic [31:0] expv [8];
    logic [31:0] held_data;
    logic [2:0]  held_idx;
    n  = (sel_i == 2) ? 2 : 8;
    br = (sel_i != 1);
    for (int i = 0; i < 8; i++) mem[i] = ramp ? {16'(i), 16'(100 + i)} : $urandom;
    for (int i = 0; i < n; i++) expv[i] = mem[ref_map(i, n, br)];
    sel = sel_i;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    if (!spam) start = 1'b0;
    check("fetch_busy", 32'(o_busy), 32'd1);
    check("fetch_valid", 32'(o_valid), 32'd0);
    check("fetch_addr1", 32'(o_a1), 32'(ref_map(0, n, br)));
    check("fetch_addr2", 32'(o_a2), 32'(ref_map(1, n, br)));
    k = 0; cyc = 0; rcnt = 0; stalled = 1'b0; aborted = 1'b0;
    while (k < n && cyc < 100 && !aborted) begin
      @(negedge clk);
      cyc++;
      case (ready_mode)
        0:       rv = 1'b1;
        1:       rv = (rcnt % 3 == 0);
        default: rv = 1'($urandom % 2);
      endcase
      rcnt++;
      ready = rv;
      check("valid", 32'(o_valid), 32'd1);
      check("busy", 32'(o_busy), 32'd1);
      if (stalled) begin
        check("stall_data", o_data, held_data);
        check("stall_index", 32'(o_idx), 32'(held_idx));
      end
      if (rv) begin
        check("data", o_data, expv[k]);
        check("index", 32'(o_idx), 32'(k));
        check("last", 32'(o_last), 32'(k == n - 1));
        if (k % 2 == 1 && k < n - 1) begin
          check("addr1", 32'(o_a1), 32'(ref_map(k + 1, n, br)));
          check("addr2", 32'(o_a2), 32'(ref_map(k + 2, n, br)));
        end
        if (k == abort_at) begin
          rst = 1'b1;
          aborted = 1'b1;
        end
        k++;
        stalled = 1'b0;
      end else begin
        held_data = o_data;
        held_idx  = o_idx;
        stalled   = 1'b1;
      end
    end
    if (aborted) begin
      @(negedge clk);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_last", 32'(o_last), 32'd0);
      check("rst_index", 32'(o_idx), 32'd0);
      check("rst_data", o_data, 32'd0);
      check("rst_addr1", 32'(o_a1), 32'd0);
      check("rst_addr2", 32'(o_a2), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check("rst_no_done", 32'(o_done), 32'd0);
        check("rst_idle", 32'(o_valid), 32'd0);
      end
      return;
    end
    if (k < n) check("timeout", 32'(k), 32'(n));
    @(negedge clk);
    start = 1'b0;
    check("done", 32'(o_done), 32'd1);
    check("done_busy", 32'(o_busy), 32'd0);
    check("done_valid", 32'(o_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_done", 32'(o_done), 32'd0);
      check("post_busy", 32'(o_busy), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b0; sel = 0;
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_done", 32'(o_done), 32'd0);
    check("reset_index", 32'(o_idx), 32'd0);
    check("reset_data", o_data, 32'd0);
    check("reset_addr1", 32'(o_a1), 32'd0);
    check("reset_addr2", 32'(o_a2), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_frame(0, 0, 1'b0, -1, 1'b1);   // bit-reversed, ready held high
    run_frame(0, 1, 1'b0, -1, 1'b1);   // ready 1,0,0 pattern
    run_frame(0, 2, 1'b0, -1, 1'b0);   // random ready, random RAM
    run_frame(1, 0, 1'b0, -1, 1'b1);   // natural order
    run_frame(1, 2, 1'b0, -1, 1'b0);
    run_frame(0, 0, 1'b1, -1, 1'b0);   // start held high while busy
    run_frame(0, 0, 1'b0, 3, 1'b0);    // reset on the 4th accepted sample
    run_frame(0, 0, 1'b0, -1, 1'b0);   // full frame after abort
    run_frame(2, 0, 1'b0, -1, 1'b1);   // N=2
    run_frame(2, 1, 1'b0, -1, 1'b0);
    for (int r = 0; r < 4; r++) run_frame(r % 3, 2, 1'(r % 2), -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
